// File: rtl/f32_pkg.sv
// Shared single-precision float constants, field widths and state encodings
// for the sequential multiply and divide/reciprocal datapaths.
package f32_pkg;

  localparam int F32_WIDTH = 32;
  localparam int F32_EXPW  = 8;
  localparam int F32_MANW  = 23;
  localparam int F32_SIGW  = F32_MANW + 1;
  localparam int F32_PRODW = 2 * F32_SIGW;
  localparam int F32_EW    = 10;

  localparam logic signed [F32_EW-1:0] F32_BIAS    = 10'sd127;
  localparam logic signed [F32_EW-1:0] F32_EXP_MAX = 10'sd255;

  localparam logic [F32_WIDTH-1:0] F32_ONE  = 32'h3f80_0000;
  localparam logic [F32_WIDTH-1:0] F32_INF  = 32'h7f80_0000;
  localparam logic [F32_WIDTH-1:0] F32_QNAN = 32'h7fc0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } f32_class_t;

  // Denormals fold into CLS_ZERO since they are flushed on input.
  function automatic f32_class_t f32_classify(input logic [F32_WIDTH-1:0] x);
    f32_class_t cls;
    if (x[F32_WIDTH-2 -: F32_EXPW] == '1) begin
      cls = (x[F32_MANW-1:0] != '0) ? CLS_NAN : CLS_INF;
    end else if (x[F32_WIDTH-2 -: F32_EXPW] == '0) begin
      cls = CLS_ZERO;
    end else begin
      cls = CLS_NORMAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/f32_round_pack.sv
// Combinational normalize / round-to-nearest-even / pack of a 48-bit
// significand product with a signed 10-bit biased exponent.
module f32_round_pack
  import f32_pkg::*;
(
  input  logic                     sign,
  input  logic signed [F32_EW-1:0] exp_in,
  input  logic [F32_PRODW-1:0]     prod,
  input  f32_class_t               cls,
  output logic [F32_WIDTH-1:0]     result,
  output logic                     ovf,
  output logic                     unf,
  output logic                     inv
);

  logic [F32_SIGW-1:0]     sig;
  logic                    guard_bit;
  logic                    sticky_bit;
  logic                    round_up;
  logic [F32_SIGW:0]       sig_rnd;
  logic [F32_MANW-1:0]     frac;
  logic signed [F32_EW-1:0] e_norm;
  logic signed [F32_EW-1:0] e_rnd;

  always_comb begin
    sig        = '0;
    guard_bit  = 1'b0;
    sticky_bit = 1'b0;
    e_norm     = exp_in;
    if (prod[F32_PRODW-1]) begin
      sig        = prod[F32_PRODW-1 -: F32_SIGW];
      guard_bit  = prod[F32_PRODW-F32_SIGW-1];
      sticky_bit = |prod[F32_PRODW-F32_SIGW-2:0];
      e_norm     = exp_in + 10'sd1;
    end else begin
      sig        = prod[F32_PRODW-2 -: F32_SIGW];
      guard_bit  = prod[F32_PRODW-F32_SIGW-2];
      sticky_bit = |prod[F32_PRODW-F32_SIGW-3:0];
    end

    round_up = guard_bit & (sticky_bit | sig[0]);
    sig_rnd  = {1'b0, sig} + {{F32_SIGW{1'b0}}, round_up};

    // Rounding can only carry out to exactly 2.0, leaving a zero fraction.
    if (sig_rnd[F32_SIGW]) begin
      e_rnd = e_norm + 10'sd1;
      frac  = sig_rnd[F32_SIGW-1:1];
    end else begin
      e_rnd = e_norm;
      frac  = sig_rnd[F32_MANW-1:0];
    end
  end

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unf    = 1'b0;
    inv    = 1'b0;
    case (cls)
      CLS_NAN: begin
        result = F32_QNAN;
        inv    = 1'b1;
      end
      CLS_INF:  result = {sign, F32_INF[F32_WIDTH-2:0]};
      CLS_ZERO: result = {sign, {(F32_WIDTH-1){1'b0}}};
      default: begin
        if (e_rnd >= F32_EXP_MAX) begin
          result = {sign, F32_INF[F32_WIDTH-2:0]};
          ovf    = 1'b1;
        end else if (e_rnd <= 10'sd0) begin
          result = {sign, {(F32_WIDTH-1){1'b0}}};
          unf    = 1'b1;
        end else begin
          result = {sign, e_rnd[F32_EXPW-1:0], frac};
        end
      end
    endcase
  end

endmodule

// File: rtl/mult_seq_f32.sv
// Sequential single-precision multiplier, radix-2 shift-add, fixed 26-cycle latency.
// Define MULT_SEQ_F32_STATUS_EN to add the ovf/unf/inv status outputs.
module mult_seq_f32
  import f32_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int EXPONENTWIDTH = 8,
  parameter int MANTISSAWIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             rdy,
`ifdef MULT_SEQ_F32_STATUS_EN
  output logic             ovf,
  output logic             unf,
  output logic             inv,
`endif
  output logic [WIDTH-1:0] m
);

  localparam int SIGW  = MANTISSAWIDTH + 1;
  localparam int PRODW = 2 * SIGW;

  mul_state_t state_reg, state_next;

  logic [4:0]               cnt_reg;
  logic [SIGW-1:0]          mcand_reg;
  logic [PRODW-1:0]         prod_reg;
  logic [PRODW-1:0]         prod_next;
  logic [SIGW:0]            add_sum;
  logic                     sign_reg;
  logic signed [F32_EW-1:0] exp_reg;
  f32_class_t               cls_reg;
  logic [WIDTH-1:0]         m_reg;
  logic                     rdy_reg;
  logic                     accept;

  logic [WIDTH-1:0]         op     [2];
  f32_class_t               op_cls [2];
  logic [SIGW-1:0]          op_sig [2];
  logic [F32_EW-1:0]        op_exp [2];

  assign op[0] = a;
  assign op[1] = b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      assign op_cls[gi] = f32_classify(op[gi]);
      assign op_sig[gi] = (op_cls[gi] == CLS_ZERO) ? '0 : {1'b1, op[gi][MANTISSAWIDTH-1:0]};
      assign op_exp[gi] = {{(F32_EW-EXPONENTWIDTH){1'b0}}, op[gi][WIDTH-2 -: EXPONENTWIDTH]};
    end
  endgenerate

  logic                     any_nan;
  logic                     any_inf;
  logic                     any_zero;
  f32_class_t               res_cls;
  logic signed [F32_EW-1:0] exp_sum;

  assign any_nan  = (op_cls[0] == CLS_NAN) || (op_cls[1] == CLS_NAN) ||
                    (op_cls[0] == CLS_INF && op_cls[1] == CLS_ZERO) ||
                    (op_cls[0] == CLS_ZERO && op_cls[1] == CLS_INF);
  assign any_inf  = (op_cls[0] == CLS_INF) || (op_cls[1] == CLS_INF);
  assign any_zero = (op_cls[0] == CLS_ZERO) || (op_cls[1] == CLS_ZERO);
  assign res_cls  = any_nan  ? CLS_NAN  :
                    any_inf  ? CLS_INF  :
                    any_zero ? CLS_ZERO : CLS_NORMAL;
  assign exp_sum  = $signed(op_exp[0]) + $signed(op_exp[1]) - F32_BIAS;

  assign accept = (state_reg == ST_IDLE) && start;
  assign busy   = (state_reg != ST_IDLE);
  assign rdy    = rdy_reg;
  assign m      = m_reg;

  // Right-shifting accumulator: upper half gathers partial sums while the
  // multiplier bits drain out of the lower half, LSB first.
  assign add_sum   = {1'b0, prod_reg[PRODW-1:SIGW]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
  assign prod_next = {add_sum, prod_reg[SIGW-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_MUL;
      ST_MUL:  if (cnt_reg == 5'(SIGW - 1)) state_next = ST_NORM;
      ST_NORM: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  logic [F32_WIDTH-1:0] rp_result;
  logic                 rp_ovf;
  logic                 rp_unf;
  logic                 rp_inv;

  f32_round_pack u_round_pack (
    .sign   (sign_reg),
    .exp_in (exp_reg),
    .prod   (prod_reg),
    .cls    (cls_reg),
    .result (rp_result),
    .ovf    (rp_ovf),
    .unf    (rp_unf),
    .inv    (rp_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      mcand_reg <= '0;
      prod_reg  <= '0;
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      cls_reg   <= CLS_ZERO;
      m_reg     <= '0;
      rdy_reg   <= 1'b0;
    end else begin
      rdy_reg <= (state_reg == ST_NORM);
      if (accept) begin
        cnt_reg   <= '0;
        mcand_reg <= op_sig[0];
        prod_reg  <= {{SIGW{1'b0}}, op_sig[1]};
        sign_reg  <= op[0][WIDTH-1] ^ op[1][WIDTH-1];
        exp_reg   <= exp_sum;
        cls_reg   <= res_cls;
      end else if (state_reg == ST_MUL) begin
        cnt_reg  <= cnt_reg + 5'd1;
        prod_reg <= prod_next;
      end
      if (state_reg == ST_NORM) begin
        m_reg <= rp_result;
      end
    end
  end

`ifdef MULT_SEQ_F32_STATUS_EN
  logic ovf_reg, unf_reg, inv_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
      inv_reg <= 1'b0;
    end else if (state_reg == ST_NORM) begin
      ovf_reg <= rp_ovf;
      unf_reg <= rp_unf;
      inv_reg <= rp_inv;
    end
  end

  assign ovf = ovf_reg;
  assign unf = unf_reg;
  assign inv = inv_reg;
`else
  logic status_unused;
  assign status_unused = rp_ovf ^ rp_unf ^ rp_inv;
`endif

endmodule

// File: tb/tb_mult_seq_f32.sv
// Self-checking bench for mult_seq_f32: directed vectors, randomized operands
// against an arithmetic reference model, reset-abort and start-while-busy cases.
module tb_mult_seq_f32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        rdy;
  logic [31:0] m;
`ifdef MULT_SEQ_F32_STATUS_EN
  logic        ovf;
  logic        unf;
  logic        inv;
`endif

  int passes = 0;
  int checks = 0;

  mult_seq_f32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .rdy   (rdy),
`ifdef MULT_SEQ_F32_STATUS_EN
    .ovf   (ovf),
    .unf   (unf),
    .inv   (inv),
`endif
    .m     (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: exact integer significand product, rounded to 24 bits by
  // remainder comparison. Returns {m, ovf, unf, inv}.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    logic              s;
    int                ex, ey, e, sh;
    longint unsigned   p, q, r, half;
    logic              xnan, ynan, xinf, yinf, xzero, yzero;
    logic [31:0]       res;
    s     = x[31] ^ y[31];
    ex    = int'(x[30:23]);
    ey    = int'(y[30:23]);
    xnan  = (ex == 255) && (x[22:0] != 0);
    ynan  = (ey == 255) && (y[22:0] != 0);
    xinf  = (ex == 255) && (x[22:0] == 0);
    yinf  = (ey == 255) && (y[22:0] == 0);
    xzero = (ex == 0);
    yzero = (ey == 0);
    if (xnan || ynan || (xinf && yzero) || (yinf && xzero)) return {32'h7fc00000, 3'b001};
    if (xinf || yinf) return {s, 31'h7f800000, 3'b000};
    if (xzero || yzero) return {s, 31'h0, 3'b000};
    p  = (64'h800000 + 64'(x[22:0])) * (64'h800000 + 64'(y[22:0]));
    sh = 0;
    while ((p >> sh) >= 64'h1000000) sh++;
    q    = p >> sh;
    r    = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == 64'h1000000) begin
      q  = q >> 1;
      sh = sh + 1;
    end
    e = sh + ex + ey - 150;
    if (e >= 255) return {s, 31'h7f800000, 3'b100};
    if (e <= 0)   return {s, 31'h0, 3'b010};
    res = {s, 8'(e), q[22:0]};
    return {res, 3'b000};
  endfunction

  // Drives one request; dup_at>0 pulses a second start in that busy cycle.
  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input int dup_at,
                        output logic [31:0] mo, output int lat, output logic [2:0] sto);
    a     = xa;
    b     = xb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    chk("busy_at_accept", {31'd0, busy}, 32'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == dup_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (rdy === 1'b1) begin
        lat = k;
        break;
      end
    end
    mo = m;
`ifdef MULT_SEQ_F32_STATUS_EN
    sto = {ovf, unf, inv};
`else
    sto = 3'b000;
`endif
  endtask

  task automatic check_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] exp_m, input logic [2:0] exp_st, input int dup_at);
    logic [31:0] mo;
    int          lat;
    logic [2:0]  sto;
    run_op(xa, xb, dup_at, mo, lat, sto);
    $display("op %s a=%h b=%h m=%h exp=%h rdy_cycle=%0d st=%b", tag, xa, xb, mo, exp_m, lat + 1, sto);
    chk({tag, "_rdy_cycle"}, 32'(lat + 1), 32'd26);
    chk({tag, "_m"}, mo, exp_m);
`ifdef MULT_SEQ_F32_STATUS_EN
    chk({tag, "_status"}, {29'd0, sto}, {29'd0, exp_st});
`else
    if (exp_st != sto) $display("note %s status flags not built", tag);
`endif
  endtask

  logic [31:0] da   [11] = '{32'h3f800000, 32'h40400000, 32'hc0400000, 32'h7f000000,
                             32'h7f800000, 32'h7fc00001, 32'h00800000, 32'h80800000,
                             32'hff800000, 32'h80000000, 32'h007fffff};
  logic [31:0] db   [11] = '{32'h40000000, 32'h3eaaaaab, 32'h3eaaaaab, 32'h40000000,
                             32'h00000000, 32'h3f800000, 32'h3f000000, 32'h3f000000,
                             32'h40000000, 32'h3f800000, 32'h40000000};
  logic [31:0] dm   [11] = '{32'h40000000, 32'h3f800000, 32'hbf800000, 32'h7f800000,
                             32'h7fc00000, 32'h7fc00000, 32'h00000000, 32'h80000000,
                             32'hff800000, 32'h80000000, 32'h00000000};
  logic [2:0]  dst  [11] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b001,
                             3'b010, 3'b010, 3'b000, 3'b000, 3'b000};

  function automatic logic [31:0] rand_f32();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = int'($urandom_range(0, 19));
    f   = 23'($urandom);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) begin
      e = 8'hff;
      if ($urandom_range(0, 1) == 0) f = '0;
    end
    else e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, f};
  endfunction

  initial begin
    logic [34:0] ref_v;
    logic [31:0] ra, rb, mo, held;
    int          lat, seen;
    logic [2:0]  sto;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rdy", {31'd0, rdy}, 32'd0);
    chk("reset_m", m, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      check_op($sformatf("dir%0d", i), da[i], db[i], dm[i], dst[i], 0);
      @(posedge clk); #1;
      chk("idle_after_done", {30'd0, busy, rdy}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      ra    = rand_f32();
      rb    = rand_f32();
      ref_v = model(ra, rb);
      check_op($sformatf("rnd%0d", i), ra, rb, ref_v[34:3], ref_v[2:0], 0);
      @(posedge clk); #1;
    end

    // Abort mid-operation with reset.
    a     = 32'h40400000;
    b     = 32'h40400000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_m", m, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) seen++;
    end
    $display("op abort rdy_pulses_after_reset=%0d m=%h", seen, m);
    chk("abort_no_rdy", 32'(seen), 32'd0);
    chk("abort_m_held", m, 32'd0);
    check_op("post_abort", 32'h40400000, 32'h40400000, 32'h41100000, 3'b000, 0);

    // Second start while busy is ignored; start in the rdy cycle is ignored.
    @(posedge clk); #1;
    check_op("dup_start", 32'h3fc00000, 32'h40000000, 32'h40400000, 3'b000, 7);
    held  = m;
    a     = 32'h40800000;
    b     = 32'h40800000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_ignored", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1 || busy === 1'b1) seen++;
    end
    $display("op ignored_starts active_cycles=%0d m=%h", seen, m);
    chk("no_queued_op", 32'(seen), 32'd0);
    chk("m_hold", m, held);

    run_op(32'h40a00000, 32'h3e800000, 0, mo, lat, sto);
    $display("op final a=40a00000 b=3e800000 m=%h rdy_cycle=%0d", mo, lat + 1);
    chk("final_m", mo, 32'h3fa00000);
    chk("final_rdy_cycle", 32'(lat + 1), 32'd26);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
